// File: rtl/ogege_cmd_pkg.sv
// Shared definitions for the text-area command scheduler: command width,
// opcodes, issue FSM states and command field helpers.
package ogege_cmd_pkg;

  localparam int CMD_W = 32;

  localparam logic [3:0] OP_SCROLL = 4'h3;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DRIVE,
    RECOVER
  } sched_state_e;

  // Last count value in each timed state. The strobe is high for DRIVE_LAST+1
  // clocks. RECOVER is short because the IDLE and ARM cycles complete the
  // 5-clock low phase, so back-to-back strobes sit exactly two pixel clocks apart.
  localparam logic [2:0] DRIVE_LAST   = 3'd4;
  localparam logic [2:0] RECOVER_LAST = 3'd2;

  function automatic logic [3:0] cmd_opcode(input logic [CMD_W-1:0] cmd);
    return cmd[31:28];
  endfunction

  function automatic logic [27:0] cmd_payload(input logic [CMD_W-1:0] cmd);
    return cmd[27:0];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO. The head is always visible while
// non-empty. Push and pop may occur in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk_125mhz,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and level define which entries are valid.
  always_ff @(posedge clk_125mhz) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the clock edge, whatever order the statements run in.
  always_ff @(posedge clk_125mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Round-robin command scheduler feeding text_area8x8 with pixel-clock-aligned
// strobes. Define CMD_SCHED_VBLANK_GATE_EN to hold GATED_OPCODE heads until vblank.
module cmd_scheduler
  import ogege_cmd_pkg::*;
#(
  parameter int         DEPTH        = 8,
  parameter logic [3:0] GATED_OPCODE = OP_SCROLL
) (
  input  logic                    clk_125mhz,
  input  logic                    rstn_i,
  input  logic                    i_pix_ce,
  input  logic                    i_vblank,
  input  logic                    i_host_valid,
  input  logic [CMD_W-1:0]        i_host_data,
  output logic                    o_host_ready,
  input  logic                    i_auto_valid,
  input  logic [CMD_W-1:0]        i_auto_data,
  output logic                    o_auto_ready,
  output logic                    o_cmd_clk,
  output logic [CMD_W-1:0]        o_cmd_data,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_busy
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic             run_q;
  logic             prio_host_q;
  logic             grant_host;
  logic             grant_auto;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CMD_W-1:0] push_data;
  logic [CMD_W-1:0] head;
  logic [LW-1:0]    level;
  logic             head_issuable;

  sched_state_e     state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             cmd_clk_q, cmd_clk_d;
  logic             load_data;
  logic [CMD_W-1:0] cmd_data_q;

  // run_q keeps both readies low while reset is asserted.
  always_comb begin
    grant_host = i_host_valid && (!i_auto_valid || prio_host_q);
    grant_auto = i_auto_valid && !grant_host;
  end

  assign o_host_ready = run_q && grant_host && !full;
  assign o_auto_ready = run_q && grant_auto && !full;
  assign push         = o_host_ready || o_auto_ready;
  assign push_data    = o_host_ready ? i_host_data : i_auto_data;

  always_ff @(posedge clk_125mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      run_q       <= 1'b0;
      prio_host_q <= 1'b1;
    end else begin
      run_q <= 1'b1;
      if (push) prio_host_q <= o_auto_ready;
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_125mhz (clk_125mhz),
    .rstn_i     (rstn_i),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .level      (level),
    .full       (full),
    .empty      (empty)
  );

`ifdef CMD_SCHED_VBLANK_GATE_EN
  assign head_issuable = (cmd_opcode(head) != GATED_OPCODE) || i_vblank;
`else
  logic unused_cfg;
  assign unused_cfg    = ^{i_vblank, GATED_OPCODE};
  assign head_issuable = 1'b1;
`endif

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_clk_d = cmd_clk_q;
    load_data = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && head_issuable) state_d = ARM;
      end
      ARM: begin
        // Committed: the vblank gate is not re-checked here.
        if (i_pix_ce) begin
          load_data = 1'b1;
          pop       = 1'b1;
          cmd_clk_d = 1'b1;
          cnt_d     = '0;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          cmd_clk_d = 1'b0;
          cnt_d     = '0;
          state_d   = RECOVER;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == RECOVER_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_125mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_clk_q  <= 1'b0;
      cmd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_clk_q <= cmd_clk_d;
      if (load_data) cmd_data_q <= head;
    end
  end

  assign o_cmd_clk  = cmd_clk_q;
  assign o_cmd_data = cmd_data_q;
  assign o_level    = level;
  assign o_busy     = (state_q != IDLE) || (level != '0);

endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: arbitration vector table, directed
// strobe/ordering/reset/gating sequences and a randomized run against a model.
module tb_cmd_scheduler;
  import ogege_cmd_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] H_BASE = 32'h1100_0000;
  localparam logic [31:0] A_BASE = 32'h2200_0000;

  logic             clk_125mhz = 1'b0;
  logic             rstn_i = 1'b0;
  logic             i_pix_ce = 1'b0;
  logic             i_vblank = 1'b0;
  logic             i_host_valid = 1'b0;
  logic [31:0]      i_host_data = '0;
  logic             i_auto_valid = 1'b0;
  logic [31:0]      i_auto_data = '0;
  logic             o_host_ready;
  logic             o_auto_ready;
  logic             o_cmd_clk;
  logic [31:0]      o_cmd_data;
  logic [LW-1:0]    o_level;
  logic             o_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int div      = 1;
  bit pix_en   = 1'b0;

  cmd_scheduler #(.DEPTH(DEPTH), .GATED_OPCODE(OP_SCROLL)) dut (
    .clk_125mhz   (clk_125mhz),
    .rstn_i       (rstn_i),
    .i_pix_ce     (i_pix_ce),
    .i_vblank     (i_vblank),
    .i_host_valid (i_host_valid),
    .i_host_data  (i_host_data),
    .o_host_ready (o_host_ready),
    .i_auto_valid (i_auto_valid),
    .i_auto_data  (i_auto_data),
    .o_auto_ready (o_auto_ready),
    .o_cmd_clk    (o_cmd_clk),
    .o_cmd_data   (o_cmd_data),
    .o_level      (o_level),
    .o_busy       (o_busy)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  always @(posedge clk_125mhz) cyc <= cyc + 1;

  // Pixel clock enable: one cycle in five while enabled.
  always @(posedge clk_125mhz) begin
    #1;
    if (pix_en) div = (div == 4) ? 0 : div + 1;
    else        div = 1;
    i_pix_ce = pix_en && (div == 0);
  end

  typedef struct {
    bit          hv;
    bit          av;
    bit          exp_hr;
    bit          exp_ar;
    int          exp_level;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rstn_i       = 1'b0;
    i_host_valid = 1'b0;
    i_auto_valid = 1'b0;
    repeat (3) @(posedge clk_125mhz);
    #1 rstn_i = 1'b1;
    @(posedge clk_125mhz);
    #1;
  endtask

  task automatic push_one(input bit host, input logic [31:0] d, output int push_cyc);
    @(posedge clk_125mhz); #1;
    if (host) begin i_host_valid = 1'b1; i_host_data = d; end
    else      begin i_auto_valid = 1'b1; i_auto_data = d; end
    @(negedge clk_125mhz);
    check(host ? "push_host_ready" : "push_auto_ready", host ? o_host_ready : o_auto_ready, 1);
    push_cyc = cyc;
    @(posedge clk_125mhz); #1;
    i_host_valid = 1'b0;
    i_auto_valid = 1'b0;
  endtask

  // Waits for a low-then-high strobe transition and measures the pulse.
  task automatic get_strobe(input int budget, output logic [31:0] d, output int rise,
                            output int width, output int pix_hits, output bit ok);
    bit seen_low = 1'b0;
    ok = 1'b0; d = '0; rise = -1; width = 0; pix_hits = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_125mhz);
      if (!o_cmd_clk) seen_low = 1'b1;
      else if (seen_low) begin
        ok = 1'b1; rise = cyc; d = o_cmd_data;
        break;
      end
    end
    if (ok) begin
      while (o_cmd_clk && width < 20) begin
        width++;
        if (i_pix_ce) pix_hits++;
        @(negedge clk_125mhz);
      end
    end
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [31:0] d = $urandom;
    if (d[31:28] == OP_SCROLL) d[31:28] = 4'h4;
    return d;
  endfunction

  // Reference model: strobe issues on a pix_ce cycle t once the head was pushed
  // at or before t-2 and the previous issue was at least 10 clocks earlier.
  task automatic run_random(input int n);
    logic [31:0] mq_d[$];
    int          mq_t[$];
    bit          prio_host = 1'b1;
    int          last = -100;
    logic [31:0] last_data = '0;
    bit          full, e_hr, e_ar, issue, e_clk, e_busy;
    int          pct;
    for (int t = 0; t < n; t++) begin
      @(posedge clk_125mhz); #1;
      pct = ((t / 150) % 2 == 0) ? 10 : 55;
      i_host_valid = ($urandom_range(0, 99) < pct);
      i_auto_valid = ($urandom_range(0, 99) < pct);
      i_host_data  = rand_cmd();
      i_auto_data  = rand_cmd();
      i_vblank     = $urandom_range(0, 1);
      @(negedge clk_125mhz);
      full   = (mq_d.size() == DEPTH);
      e_hr   = !full && i_host_valid && (!i_auto_valid || prio_host);
      e_ar   = !full && i_auto_valid && (!i_host_valid || !prio_host);
      e_clk  = (t >= last + 1) && (t <= last + 5);
      e_busy = (mq_d.size() != 0) || ((t >= last + 1) && (t <= last + 8));
      check("rnd_host_ready", o_host_ready, e_hr);
      check("rnd_auto_ready", o_auto_ready, e_ar);
      check("rnd_level", o_level, mq_d.size());
      check("rnd_cmd_clk", o_cmd_clk, e_clk);
      check("rnd_cmd_data", o_cmd_data, last_data);
      check("rnd_busy", o_busy, e_busy);
      issue = (mq_d.size() != 0) && i_pix_ce && (t >= mq_t[0] + 2) && (t >= last + 10);
      if (issue) begin
        last      = t;
        last_data = mq_d.pop_front();
        void'(mq_t.pop_front());
      end
      if (e_hr) begin mq_d.push_back(i_host_data); mq_t.push_back(t); end
      if (e_ar) begin mq_d.push_back(i_auto_data); mq_t.push_back(t); end
      if (e_hr || e_ar) prio_host = e_ar;
    end
    i_host_valid = 1'b0;
    i_auto_valid = 1'b0;
  endtask

  initial begin
    vec_t        vecs[12];
    logic [31:0] d;
    logic [31:0] exp_q[$];
    int          rise, prev_rise, width, hits, pc, h_idx, a_idx, strobes, vb_cyc;
    bit          ok, exp_h;

    // Reset state, with both requesters valid.
    i_host_valid = 1'b1;
    i_auto_valid = 1'b1;
    repeat (2) @(negedge clk_125mhz);
    check("rst_cmd_clk", o_cmd_clk, 0);
    check("rst_cmd_data", o_cmd_data, 0);
    check("rst_level", o_level, 0);
    check("rst_busy", o_busy, 0);
    check("rst_host_ready", o_host_ready, 0);
    check("rst_auto_ready", o_auto_ready, 0);

    // Arbitration table, no pops (pixel enable off).
    vecs = '{
      '{0, 0, 0, 0, 0}, '{1, 0, 1, 0, 0}, '{1, 1, 0, 1, 1}, '{1, 1, 1, 0, 2},
      '{0, 1, 0, 1, 3}, '{1, 1, 1, 0, 4}, '{0, 0, 0, 0, 5}, '{1, 1, 0, 1, 5},
      '{1, 1, 1, 0, 6}, '{1, 1, 0, 1, 7}, '{1, 1, 0, 0, 8}, '{0, 1, 0, 0, 8}
    };
    pix_en = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_125mhz); #1;
      i_host_valid = vecs[i].hv;
      i_auto_valid = vecs[i].av;
      i_host_data  = H_BASE + i;
      i_auto_data  = A_BASE + i;
      @(negedge clk_125mhz);
      check("tbl_host_ready", o_host_ready, vecs[i].exp_hr);
      check("tbl_auto_ready", o_auto_ready, vecs[i].exp_ar);
      check("tbl_level", o_level, vecs[i].exp_level);
    end

    // Both valid every cycle: H,A alternation, fill, then pop-while-full.
    pix_en = 1'b0;
    do_reset();
    h_idx = 0; a_idx = 0;
    i_host_valid = 1'b1; i_auto_valid = 1'b1;
    i_host_data = H_BASE; i_auto_data = A_BASE;
    for (int k = 0; k < 8; k++) begin
      exp_h = (k % 2 == 0);
      @(negedge clk_125mhz);
      check("rr_host_ready", o_host_ready, exp_h);
      check("rr_auto_ready", o_auto_ready, !exp_h);
      @(posedge clk_125mhz); #1;
      if (exp_h) begin h_idx++; i_host_data = H_BASE + h_idx; end
      else       begin a_idx++; i_auto_data = A_BASE + a_idx; end
    end
    @(negedge clk_125mhz);
    check("full_level", o_level, DEPTH);
    check("full_host_ready", o_host_ready, 0);
    check("full_auto_ready", o_auto_ready, 0);
    @(posedge clk_125mhz); #1;
    pix_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_125mhz);
      if (o_cmd_clk) begin ok = 1'b1; break; end
      check("full_rdy_low", o_host_ready | o_auto_ready, 0);
    end
    check("full_first_strobe_seen", ok, 1);
    prev_rise = cyc;
    check("pop_level", o_level, DEPTH - 1);
    check("pop_next_host_ready", o_host_ready, 1);
    check("pop_next_auto_ready", o_auto_ready, 0);
    check("first_data", o_cmd_data, H_BASE);
    @(posedge clk_125mhz); #1;
    i_host_valid = 1'b0; i_auto_valid = 1'b0;
    @(negedge clk_125mhz);
    check("refill_level", o_level, DEPTH);
    exp_q = '{A_BASE, H_BASE + 1, A_BASE + 1, H_BASE + 2, A_BASE + 2,
              H_BASE + 3, A_BASE + 3, H_BASE + 4};
    foreach (exp_q[i]) begin
      get_strobe(30, d, rise, width, hits, ok);
      check("seq_strobe_seen", ok, 1);
      check("seq_data", d, exp_q[i]);
      check("seq_spacing", rise - prev_rise, 10);
      check("seq_width", width, 5);
      prev_rise = rise;
    end

    // Single host push: latency, width, data and pixel-edge sampling.
    pix_en = 1'b1;
    do_reset();
    push_one(1'b1, 32'h1000_00AB, pc);
    get_strobe(20, d, rise, width, hits, ok);
    check("single_strobe_seen", ok, 1);
    check("single_latency_ok", (rise - pc >= 3) && (rise - pc <= 7), 1);
    check("single_width", width, 5);
    check("single_data", d, 32'h1000_00AB);
    check("single_pix_hits", hits, 1);
    repeat (6) @(negedge clk_125mhz);
    check("single_idle_busy", o_busy, 0);
    check("single_hold_data", o_cmd_data, 32'h1000_00AB);

    // Reset during DRIVE.
    do_reset();
    push_one(1'b1, 32'h1000_0001, pc);
    push_one(1'b1, 32'h1000_0002, pc);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_125mhz);
      if (o_cmd_clk) begin ok = 1'b1; break; end
    end
    check("rstdrv_strobe_seen", ok, 1);
    #1 rstn_i = 1'b0;
    i_host_valid = 1'b1;
    #1;
    check("rstdrv_cmd_clk", o_cmd_clk, 0);
    check("rstdrv_level", o_level, 0);
    check("rstdrv_busy", o_busy, 0);
    check("rstdrv_host_ready", o_host_ready, 0);
    i_host_valid = 1'b0;
    repeat (2) @(posedge clk_125mhz);
    #1 rstn_i = 1'b1;
    strobes = 0;
    repeat (30) begin
      @(negedge clk_125mhz);
      if (o_cmd_clk) strobes++;
    end
    check("rstdrv_no_strobe", strobes, 0);
    check("rstdrv_level_after", o_level, 0);

`ifdef CMD_SCHED_VBLANK_GATE_EN
    // Gated scroll head blocks until vblank and is not overtaken.
    i_vblank = 1'b0;
    do_reset();
    push_one(1'b1, 32'h3000_0005, pc);
    push_one(1'b0, 32'h2000_0001, pc);
    strobes = 0;
    repeat (30) begin
      @(negedge clk_125mhz);
      if (o_cmd_clk) strobes++;
    end
    check("gate_no_strobe", strobes, 0);
    check("gate_level_hold", o_level, 2);
    @(posedge clk_125mhz); #1;
    i_vblank = 1'b1;
    vb_cyc = cyc;
    get_strobe(20, d, rise, width, hits, ok);
    i_vblank = 1'b0;
    check("gate_strobe_seen", ok, 1);
    check("gate_latency_ok", (rise - vb_cyc) <= 7, 1);
    check("gate_data", d, 32'h3000_0005);
    get_strobe(30, d, rise, width, hits, ok);
    check("gate_next_seen", ok, 1);
    check("gate_next_data", d, 32'h2000_0001);
`else
    vb_cyc = 0;
`endif

    // Randomized traffic against the model.
    pix_en = 1'b1;
    do_reset();
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
